// File: rtl/mul_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the iterative 32x32 multiplier: RV32M op codes,
// control FSM states and the partial-product step sequence.
package mul_pkg;

  // RV32M multiply op select
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Half-pair sequence: low/high half of a times low/high half of b
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

endpackage

// File: rtl/mul32_iter_mul16.sv
`timescale 1ns/1ps
// Combinational 16x16 multiplier with per-operand signedness. Each operand
// is widened to 17 bits (sign or zero bit) so one signed multiply covers
// all four signedness combinations; the low 32 bits hold the exact product.
// clk/rst_n exist only for port compatibility and do not affect the result.
module Mul_16x16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic        sign1,
  input  logic        sign2,
  output logic [31:0] result
);

  logic signed [16:0] op1;
  logic signed [16:0] op2;
  logic signed [33:0] full;
  logic [2:0]         unused_bits;

  assign op1    = {sign1 & src1[15], src1};
  assign op2    = {sign2 & src2[15], src2};
  assign full   = op1 * op2;
  assign result = full[31:0];

  // Top two product bits are redundant for 16-bit inputs; clock/reset are idle.
  assign unused_bits = {clk ^ rst_n, full[33:32]};

endmodule

// File: rtl/mul32_iter.sv
`timescale 1ns/1ps
// Iterative 32x32 RV32M multiplier. One 16x16 product per cycle is
// extended, shifted and accumulated into a 64-bit register; MUL stops
// after three steps because the high-half product cannot reach bits 31:0.
//
// Handshakes: a request transfers on a rising edge where in_valid and
// in_ready are both high; a result transfers on a rising edge where
// out_valid and out_ready are both high. out_valid/result stay stable
// until that transfer, and kill drops an operation without raising
// (or while holding) out_valid.
module mul32_iter
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;

  logic [15:0] m_src1, m_src2;
  logic        m_sign1, m_sign2;
  logic [31:0] m_prod;
  logic [63:0] part;
  logic [63:0] addend;
  logic [63:0] acc_sum;
  logic        last_step;

  Mul_16x16 u_mul16 (
    .clk    (clk),
    .rst_n  (~rst),
    .src1   (m_src1),
    .src2   (m_src2),
    .sign1  (m_sign1),
    .sign2  (m_sign2),
    .result (m_prod)
  );

  // Select the half-pair for this step and align its extended product.
  always_comb begin
    m_src1  = a_q[15:0];
    m_src2  = b_q[15:0];
    m_sign1 = 1'b0;
    m_sign2 = 1'b0;
    addend  = '0;
    case (step_q)
      STEP_LL: begin
        m_src1 = a_q[15:0];
        m_src2 = b_q[15:0];
      end
      STEP_LH: begin
        m_src1  = a_q[15:0];
        m_src2  = b_q[31:16];
        m_sign2 = sb_q;
      end
      STEP_HL: begin
        m_src1  = a_q[31:16];
        m_src2  = b_q[15:0];
        m_sign1 = sa_q;
      end
      default: begin
        m_src1  = a_q[31:16];
        m_src2  = b_q[31:16];
        m_sign1 = sa_q;
        m_sign2 = sb_q;
      end
    endcase
    // A product is signed whenever either half was treated as signed.
    part = {{32{(m_sign1 | m_sign2) & m_prod[31]}}, m_prod};
    case (step_q)
      STEP_LL:          addend = part;
      STEP_LH, STEP_HL: addend = part << 16;
      default:          addend = part << 32;
    endcase
    acc_sum   = acc_q + addend;
    last_step = (step_q == STEP_HH) ||
                ((op_q == MUL_OP_MUL) && (step_q == STEP_HL));
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !kill) begin
          a_d     = src_a;
          b_d     = src_b;
          op_d    = op;
          sa_d    = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
          sb_d    = (op == MUL_OP_MULH);
          acc_d   = '0;
          step_d  = STEP_LL;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = acc_sum;
          step_d = step_q + 2'd1;
          if (last_step) begin
            state_d  = ST_DONE;
            result_d = (op_q == MUL_OP_MUL) ? acc_sum[31:0] : acc_sum[63:32];
          end
        end
      end
      ST_DONE: begin
        if (kill || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= STEP_LL;
      acc_q    <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= MUL_OP_MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_mul32_iter.sv
`timescale 1ns/1ps
// Directed bench for mul32_iter: reset values, each RV32M op with
// hand-computed products and latencies, backpressure, kill and reset abort.
module tb_mul32_iter;

  logic        clk;
  logic        rst;
  logic        kill;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int pass_cnt;
  int total_cnt;

  mul32_iter dut (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Wait (bounded) for out_valid, counting cycles since the accept edge.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Present one request for a single cycle; returns after the accept edge.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full operation: accept, check latency and result, complete handshake.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    send(o, a, b);
    wait_valid(cyc);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_result"}, result, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int cyc;
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    kill      = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;

    // Main function
    run_op("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    run_op("mul_small", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3);
    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);
    run_op("mulh_neg1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4);
    run_op("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    // -2 * 3 = -6: low word 0xFFFFFFFA, high word all ones for signed
    run_op("mul_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 3);
    run_op("mulh_neg", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 4);
    run_op("mulhu_neg", 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 4);

    // Backpressure: result held, new requests ignored while DONE
    send(2'b00, 32'h0001_0003, 32'h0002_0005);
    wait_valid(cyc);
    chk("bp_latency", cyc, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_result_stable", result, 32'h000B_000F);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid_held", out_valid, 1'b1);
      if (i == 1) begin
        in_valid = 1'b1;
        op       = 2'b11;
        src_a    = 32'hFFFF_FFFF;
        src_b    = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_in_ready_after", in_ready, 1'b1);
    chk("bp_out_valid_after", out_valid, 1'b0);
    @(negedge clk);
    chk("bp_ignored_req_busy", busy, 1'b0);

    // kill in IDLE blocks acceptance
    in_valid = 1'b1;
    kill     = 1'b1;
    op       = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    kill     = 1'b0;
    chk("kill_idle_busy", busy, 1'b0);

    // kill during step 2 (two steps already registered)
    send(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) @(negedge clk);
    chk("kill_pre_busy", busy, 1'b1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", busy, 1'b0);
    chk("kill_in_ready", in_ready, 1'b1);
    chk("kill_out_valid", out_valid, 1'b0);
    repeat (4) @(negedge clk);
    chk("kill_no_late_valid", out_valid, 1'b0);
    run_op("after_kill", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);

    // kill in DONE wins over out_ready
    send(2'b00, 32'h0000_0002, 32'h0000_0003);
    wait_valid(cyc);
    chk("kdone_result", result, 32'h0000_0006);
    kill      = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    kill      = 1'b0;
    out_ready = 1'b0;
    chk("kdone_out_valid", out_valid, 1'b0);
    chk("kdone_in_ready", in_ready, 1'b1);

    // Reset mid-CALC: outputs return to reset values immediately
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_output", out_valid, 1'b0);
    run_op("after_rst", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
